// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet framing constants, CRC settings and RX types
package eth_pkg;
  localparam logic [7:0]  ETH_PRE  = 8'h55;
  localparam logic [7:0]  ETH_SFD  = 8'hD5;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  typedef enum logic [1:0] {IDLE, PAYLOAD, WAIT_END} rx_state_t;
  typedef struct packed {
    logic [7:0] data;
    logic       dv;
    logic       er;
  } rx_beat_t;
endpackage

// File: rtl/lfsr.sv
// lfsr: one combinational Galois LFSR/CRC step over DATA_WIDTH input bits
module lfsr #(
  parameter int                    LFSR_WIDTH  = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = LFSR_WIDTH'(32'h04C11DB7),
  parameter                        LFSR_CONFIG = "GALOIS",
  parameter bit                    REVERSE     = 1'b1,
  parameter int                    DATA_WIDTH  = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [LFSR_WIDTH-1:0] state_out
);
  if (LFSR_CONFIG != "GALOIS") begin : g_bad_cfg
    $fatal(1, "lfsr: only GALOIS configuration is implemented");
  end
  // REVERSE shifts LSB-first against the bit-reflected polynomial
  function automatic logic [LFSR_WIDTH-1:0] step(input logic [LFSR_WIDTH-1:0] s,
                                                 input logic [DATA_WIDTH-1:0] d);
    logic [LFSR_WIDTH-1:0] r;
    logic [LFSR_WIDTH-1:0] p;
    r = s;
    for (int i = 0; i < LFSR_WIDTH; i++) p[i] = LFSR_POLY[LFSR_WIDTH-1-i];
    for (int i = 0; i < DATA_WIDTH; i++)
      r = REVERSE ? (r >> 1) ^ ({LFSR_WIDTH{r[0] ^ d[i]}} & p)
                  : (r << 1) ^ ({LFSR_WIDTH{r[LFSR_WIDTH-1] ^ d[DATA_WIDTH-1-i]}} & LFSR_POLY);
    return r;
  endfunction
  assign state_out = step(state_in, data_in);
endmodule

// File: rtl/axis_gmii_rx.sv
// axis_gmii_rx: GMII/MII receiver to AXI4-Stream with preamble/SFD strip and FCS check
module axis_gmii_rx
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter bit PTP_TS_ENABLE = 1'b0,
  parameter int PTP_TS_WIDTH  = 96,
  parameter int USER_WIDTH    = (PTP_TS_ENABLE ? PTP_TS_WIDTH : 0) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   gmii_rxd,
  input  logic                    gmii_rx_dv,
  input  logic                    gmii_rx_er,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  input  logic [PTP_TS_WIDTH-1:0] ptp_ts,
  input  logic                    clk_enable,
  input  logic                    mii_select,
  output logic                    start_packet,
  output logic                    error_bad_frame,
  output logic                    error_bad_fcs
);
  if (DATA_WIDTH != 8) begin : g_bad_width
    $fatal(1, "axis_gmii_rx: DATA_WIDTH must be 8");
  end
  rx_state_t   state_q, state_d;
  rx_beat_t    s_q [5];
  rx_beat_t    s_d [5];
  rx_beat_t    in_b;
  logic        odd_q, odd_d, ler_q, ler_d;
  logic [3:0]  lo_q, lo_d;
  logic [31:0] crc_q, crc_d, crc_next;
  logic        err_q, err_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d, bad_q, bad_d;
  logic        start_q, start_d, ebf_q, ebf_d, efcs_q, efcs_d;
  logic        byte_cyc, trunc, sfd_seen, sfd_ok, fcs_bad, frame_bad;
  lfsr #(
    .LFSR_WIDTH (32),
    .LFSR_POLY  (CRC_POLY),
    .LFSR_CONFIG("GALOIS"),
    .REVERSE    (1'b1),
    .DATA_WIDTH (8)
  ) eth_crc_8 (
    .data_in  (s_q[4].data),
    .state_in (crc_q),
    .state_out(crc_next)
  );
  // MII: low nibble is parked; a byte enters S0 on the high nibble or on any idle cycle
  always_comb begin
    odd_d    = odd_q;
    lo_d     = lo_q;
    ler_d    = ler_q;
    byte_cyc = 1'b0;
    trunc    = 1'b0;
    in_b     = '0;
    if (clk_enable && !mii_select) begin
      byte_cyc = 1'b1;
      odd_d    = 1'b0;
      in_b     = {gmii_rxd, gmii_rx_dv, gmii_rx_er};
    end else if (clk_enable && gmii_rx_dv && !odd_q) begin
      odd_d = 1'b1;
      lo_d  = gmii_rxd[3:0];
      ler_d = gmii_rx_er;
    end else if (clk_enable) begin
      byte_cyc = 1'b1;
      odd_d    = 1'b0;
      trunc    = !gmii_rx_dv && odd_q;
      in_b     = gmii_rx_dv ? {gmii_rxd[3:0], lo_q, 1'b1, gmii_rx_er | ler_q} : '0;
    end
    s_d = s_q;
    if (byte_cyc) begin
      s_d[0]    = in_b;
      s_d[1]    = s_q[0];
      s_d[1].er = s_q[0].er | trunc;
      s_d[2]    = s_q[1];
      s_d[3]    = s_q[2];
      s_d[4]    = s_q[3];
    end
  end
  assign sfd_seen  = s_q[4].dv && s_q[4].data == ETH_SFD;
  assign sfd_ok    = sfd_seen && s_q[0].dv && s_q[1].dv && s_q[2].dv && s_q[3].dv && in_b.dv;
  assign fcs_bad   = crc_next != ~{s_q[0].data, s_q[1].data, s_q[2].data, s_q[3].data};
  assign frame_bad = err_q | s_q[4].er | s_q[0].er | s_q[1].er | s_q[2].er | s_q[3].er | trunc;
  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    err_d    = err_q;
    tdata_d  = tdata_q;
    tvalid_d = 1'b0;
    tlast_d  = 1'b0;
    bad_d    = 1'b0;
    start_d  = 1'b0;
    ebf_d    = 1'b0;
    efcs_d   = 1'b0;
    if (byte_cyc) begin
      case (state_q)
        IDLE: begin
          start_d = sfd_ok;
          crc_d   = sfd_ok ? CRC_INIT : crc_q;
          err_d   = sfd_ok ? 1'b0 : err_q;
          state_d = sfd_ok ? PAYLOAD : (sfd_seen && in_b.dv) ? WAIT_END : IDLE;
        end
        PAYLOAD: begin
          tvalid_d = 1'b1;
          tdata_d  = s_q[4].data;
          crc_d    = crc_next;
          err_d    = err_q | s_q[4].er;
          tlast_d  = !in_b.dv;
          bad_d    = !in_b.dv && (fcs_bad || frame_bad);
          efcs_d   = !in_b.dv && fcs_bad;
          ebf_d    = !in_b.dv && frame_bad;
          state_d  = in_b.dv ? PAYLOAD : IDLE;
        end
        WAIT_END: state_d = in_b.dv ? WAIT_END : IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= '{default: '0};
      odd_q    <= 1'b0;
      lo_q     <= '0;
      ler_q    <= 1'b0;
      crc_q    <= CRC_INIT;
      err_q    <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      bad_q    <= 1'b0;
      start_q  <= 1'b0;
      ebf_q    <= 1'b0;
      efcs_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      odd_q    <= odd_d;
      lo_q     <= lo_d;
      ler_q    <= ler_d;
      crc_q    <= crc_d;
      err_q    <= err_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      bad_q    <= bad_d;
      start_q  <= start_d;
      ebf_q    <= ebf_d;
      efcs_q   <= efcs_d;
    end
  end
  if (PTP_TS_ENABLE) begin : g_ts
    logic [PTP_TS_WIDTH-1:0] ts_q, ts_d;
    always_comb ts_d = start_d ? ptp_ts : ts_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ts_q <= '0;
      else        ts_q <= ts_d;
    end
    assign m_axis_tuser = {ts_q, bad_q};
  end else begin : g_no_ts
    logic unused_ts;
    assign unused_ts    = ^ptp_ts;
    assign m_axis_tuser = bad_q;
  end
  assign m_axis_tdata    = tdata_q;
  assign m_axis_tvalid   = tvalid_q;
  assign m_axis_tlast    = tlast_q;
  assign start_packet    = start_q;
  assign error_bad_frame = ebf_q;
  assign error_bad_fcs   = efcs_q;
endmodule

// File: tb/tb_axis_gmii_rx.sv
// tb_axis_gmii_rx: directed frames in GMII and MII mode against a bench-side CRC model
module tb_axis_gmii_rx;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  gmii_rxd = '0;
  logic        gmii_rx_dv = 1'b0, gmii_rx_er = 1'b0, clk_enable = 1'b1, mii_select = 1'b0;
  logic [95:0] ptp_ts = '0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast;
  logic [96:0] m_axis_tuser;
  logic        start_packet, error_bad_frame, error_bad_fcs;
  int          tests = 0, failed = 0;
  logic [7:0]  beats[$];
  int          last_cnt, last_idx, sp_cnt, ebf_cnt, efcs_cnt, viol, ts_bad, stray, rst_beats;
  logic        last_user;
  logic [95:0] sp_ts = '0;
  logic        en_prev = 1'b0;

  axis_gmii_rx #(.DATA_WIDTH(8), .PTP_TS_ENABLE(1'b1), .PTP_TS_WIDTH(96)) dut (
    .clk(clk), .rst_n(rst_n), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .ptp_ts(ptp_ts), .clk_enable(clk_enable), .mii_select(mii_select),
    .start_packet(start_packet), .error_bad_frame(error_bad_frame), .error_bad_fcs(error_bad_fcs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ptp_ts <= ptp_ts + 96'd1;
  always @(posedge clk) en_prev <= clk_enable;

  always @(negedge clk) begin
    if (start_packet) begin
      sp_cnt++;
      sp_ts = ptp_ts - 96'd1;
    end
    if (m_axis_tvalid) begin
      beats.push_back(m_axis_tdata);
      if (m_axis_tuser[96:1] !== sp_ts) ts_bad++;
      if (!en_prev) viol++;
      if (m_axis_tlast) begin
        last_cnt++;
        last_idx  = beats.size() - 1;
        last_user = m_axis_tuser[0];
      end
    end
    if ((error_bad_frame || error_bad_fcs) && !m_axis_tlast) stray++;
    if (error_bad_frame) ebf_cnt++;
    if (error_bad_fcs) efcs_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_nib(input logic [3:0] n, input logic v, input logic e);
    gmii_rxd   = {~n, n};
    gmii_rx_dv = v;
    gmii_rx_er = e;
    clk_enable = 1'b1;
    cyc();
    clk_enable = 1'b0;
    repeat (9) cyc();
  endtask

  task automatic put_byte(input logic [7:0] d, input logic v, input logic e);
    if (!mii_select) begin
      gmii_rxd   = d;
      gmii_rx_dv = v;
      gmii_rx_er = e;
      clk_enable = 1'b1;
      cyc();
    end else begin
      put_nib(d[3:0], v, e);
      put_nib(d[7:4], v, e);
    end
  endtask

  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, 8'(i)};
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return ~c;
  endfunction

  task automatic clear_mon();
    beats.delete();
    last_cnt = 0; last_idx = -1; sp_cnt = 0; ebf_cnt = 0; efcs_cnt = 0;
    viol = 0; ts_bad = 0; stray = 0; last_user = 1'bx;
  endtask

  task automatic send_frame(input int n, input logic [7:0] fcs_x, input int er_at, input int rst_at);
    logic [31:0] fcs;
    fcs = fcs_of(n);
    repeat (7) put_byte(8'h55, 1'b1, 1'b0);
    put_byte(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        gmii_rxd   = 8'(i);
        gmii_rx_dv = 1'b1;
        gmii_rx_er = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("async_rst_tvalid", m_axis_tvalid, 0);
        chk("async_rst_tdata", m_axis_tdata, 0);
        chk("async_rst_tuser", m_axis_tuser, 0);
        rst_beats = beats.size();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end else put_byte(8'(i), 1'b1, i == er_at);
    end
    for (int j = 0; j < 4; j++) put_byte(fcs[8*j +: 8] ^ (j == 3 ? fcs_x : 8'h00), 1'b1, 1'b0);
    repeat (12) put_byte(8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_frame(input string tag, input int n, input logic user0, input int ebf, input int efcs);
    int bad;
    bad = 0;
    chk({tag, "_beats"}, beats.size(), n);
    for (int i = 0; i < beats.size() && i < n; i++) if (beats[i] !== 8'(i)) bad++;
    chk({tag, "_data_errs"}, bad, 0);
    chk({tag, "_tlast_cnt"}, last_cnt, 1);
    chk({tag, "_tlast_pos"}, last_idx, n - 1);
    chk({tag, "_tuser0"}, last_user, user0);
    chk({tag, "_start_pulses"}, sp_cnt, 1);
    chk({tag, "_bad_frame_pulses"}, ebf_cnt, ebf);
    chk({tag, "_bad_fcs_pulses"}, efcs_cnt, efcs);
    chk({tag, "_ts_errs"}, ts_bad, 0);
    chk({tag, "_stray_err_pulses"}, stray, 0);
    chk({tag, "_tvalid_no_enable"}, viol, 0);
  endtask

  initial begin
    clear_mon();
    repeat (3) cyc();
    chk("reset_tvalid", m_axis_tvalid, 0);
    chk("reset_tlast", m_axis_tlast, 0);
    chk("reset_tdata", m_axis_tdata, 0);
    chk("reset_tuser", m_axis_tuser, 0);
    chk("reset_pulses", {start_packet, error_bad_frame, error_bad_fcs}, 0);
    rst_n = 1'b1;
    repeat (4) cyc();

    clear_mon();
    send_frame(60, 8'h00, -1, -1);
    check_frame("good", 60, 1'b0, 0, 0);

    clear_mon();
    send_frame(60, 8'h01, -1, -1);
    check_frame("bad_fcs", 60, 1'b1, 0, 1);

    clear_mon();
    send_frame(60, 8'h00, 10, -1);
    check_frame("rx_er", 60, 1'b1, 1, 0);

    mii_select = 1'b1;
    clear_mon();
    repeat (4) put_byte(8'h00, 1'b0, 1'b0);
    send_frame(60, 8'h00, -1, -1);
    check_frame("mii", 60, 1'b0, 0, 0);
    mii_select = 1'b0;
    repeat (4) put_byte(8'h00, 1'b0, 1'b0);

    clear_mon();
    repeat (7) put_byte(8'h55, 1'b1, 1'b0);
    put_byte(8'hD5, 1'b1, 1'b0);
    put_byte(8'h00, 1'b1, 1'b0);
    put_byte(8'h01, 1'b1, 1'b0);
    repeat (12) put_byte(8'h00, 1'b0, 1'b0);
    chk("runt_beats", beats.size(), 0);
    chk("runt_start_pulses", sp_cnt, 0);
    chk("runt_tlast_cnt", last_cnt, 0);

    clear_mon();
    send_frame(60, 8'h00, -1, -1);
    check_frame("after_runt", 60, 1'b0, 0, 0);

    clear_mon();
    send_frame(60, 8'h00, -1, 20);
    chk("rst_frame_tlast_cnt", last_cnt, 0);
    chk("rst_frame_beats_after_reset", beats.size(), rst_beats);
    chk("rst_frame_start_pulses", sp_cnt, 1);

    clear_mon();
    send_frame(60, 8'h00, -1, -1);
    check_frame("after_reset", 60, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
